// File: rtl/led_cube_layer_scanner.sv
// -----------------------------------------------------------------------------
// led_cube_layer_scanner
//
// Purpose:
//   Scans an 8x8x8 LED cube out of the 64-byte frame held by the stream buffer.
//   For each layer it blanks the cube, then loads the eight row latches one at
//   a time over a shared 8-bit bus, and finally lights that layer for a dwell
//   period. After layer 7 it wraps back to layer 0 and keeps going for as long
//   as i_enable stays high.
//
// Optional feature (macro LED_CUBE_BRIGHTNESS_EN):
//   Adds i_brightness[3:0]. During DISPLAY, oe_n is only low while the low
//   nibble of the dwell counter is <= i_brightness, which gives a 16-step PWM.
//   layer_en is not affected. When the macro is undefined there is no
//   brightness port and oe_n stays low for the whole DISPLAY.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-high (has priority over i_enable)
//   i_enable       scanning enabled; dropping it returns to IDLE next cycle
//   i_brightness   (LED_CUBE_BRIGHTNESS_EN only) PWM level 0..15
//   i_data_in      byte from the buffer, combinational on o_frame_addr
//   o_frame_addr   byte address {layer_idx, row}
//   o_latch_data   shared row-latch data bus
//   o_latch_clk    one-hot row latch clocks (bit r = row latch r)
//   o_layer_en     one-hot layer transistor enable
//   o_oe_n         latch output enable, active-low
//   o_layer_idx    layer currently being loaded/displayed
//   o_frame_done   one-cycle pulse in the first BLANK cycle after layer 7
// -----------------------------------------------------------------------------
module led_cube_layer_scanner #(
  parameter int DWELL_CYCLES = 2000,
  parameter int BLANK_CYCLES = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
`ifdef LED_CUBE_BRIGHTNESS_EN
  input  logic [3:0] i_brightness,
`endif
  input  logic [7:0] i_data_in,
  output logic [5:0] o_frame_addr,
  output logic [7:0] o_latch_data,
  output logic [7:0] o_latch_clk,
  output logic [7:0] o_layer_en,
  output logic       o_oe_n,
  output logic [2:0] o_layer_idx,
  output logic       o_frame_done
);

  // One shared counter serves every timed state, so it is sized for the
  // longest of them.
  localparam int MAX_AB = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int MAX_CD = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXP + 1);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLANK,
    S_ADDR,
    S_SETUP,
    S_PULSE,
    S_DISPLAY
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_row;
  logic [5:0]    r_frame_addr;
  logic [7:0]    r_latch_data;
  logic [7:0]    r_latch_clk;
  logic [7:0]    r_layer_en;
  logic          r_oe_n;
  logic [2:0]    r_layer_idx;
  logic          r_frame_done;

  logic [CW-1:0] w_cnt_nx;
  assign w_cnt_nx = r_cnt + CW'(1);

`ifdef LED_CUBE_BRIGHTNESS_EN
  // oe_n is registered, so it is computed from the dwell count the next cycle
  // will show. The low nibble is zero-extended when the counter is narrow.
  logic [3:0] w_dwell_lo;
  if (CW >= 4) begin : g_lo
    assign w_dwell_lo = w_cnt_nx[3:0];
  end else begin : g_lo_ext
    assign w_dwell_lo = {{(4-CW){1'b0}}, w_cnt_nx};
  end
`endif

  // Every output is set on the transition into the state that owns it, so
  // the registered value is already correct in that state's first cycle.
  // Latch data is captured at the end of ADDR (frame_addr has been stable for
  // that whole cycle) and the latch clock only rises on leaving SETUP, so the
  // two never change on the same edge. layer_en is raised on the same edge
  // that drops the last latch clock, so they never overlap.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      // An enable drop parks the scanner exactly like reset: everything dark,
      // and the next enable starts over at layer 0.
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_row        <= 3'd0;
      r_frame_addr <= 6'd0;
      r_latch_data <= 8'd0;
      r_latch_clk  <= 8'd0;
      r_layer_en   <= 8'd0;
      r_oe_n       <= 1'b1;
      r_layer_idx  <= 3'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt       <= '0;
          r_layer_idx <= 3'd0;
          r_state     <= S_BLANK;
        end

        S_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            r_cnt        <= '0;
            r_row        <= 3'd0;
            r_frame_addr <= {r_layer_idx, 3'd0};
            r_state      <= S_ADDR;
          end else begin
            r_cnt <= w_cnt_nx;
          end
        end

        S_ADDR: begin
          r_latch_data <= i_data_in;
          r_cnt        <= '0;
          r_state      <= S_SETUP;
        end

        S_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt       <= '0;
            r_latch_clk <= 8'd1 << r_row;
            r_state     <= S_PULSE;
          end else begin
            r_cnt <= w_cnt_nx;
          end
        end

        S_PULSE: begin
          if (r_cnt == PULSE_LAST) begin
            r_cnt       <= '0;
            r_latch_clk <= 8'd0;
            if (r_row == 3'd7) begin
              r_layer_en <= 8'd1 << r_layer_idx;
              r_oe_n     <= 1'b0;
              r_state    <= S_DISPLAY;
            end else begin
              r_row        <= r_row + 3'd1;
              r_frame_addr <= {r_layer_idx, r_row + 3'd1};
              r_state      <= S_ADDR;
            end
          end else begin
            r_cnt <= w_cnt_nx;
          end
        end

        S_DISPLAY: begin
          if (r_cnt == DWELL_LAST) begin
            r_cnt        <= '0;
            r_layer_en   <= 8'd0;
            r_oe_n       <= 1'b1;
            r_layer_idx  <= r_layer_idx + 3'd1;
            r_frame_done <= (r_layer_idx == 3'd7);
            r_state      <= S_BLANK;
          end else begin
            r_cnt <= w_cnt_nx;
`ifdef LED_CUBE_BRIGHTNESS_EN
            r_oe_n <= (w_dwell_lo > i_brightness);
`endif
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_frame_addr = r_frame_addr;
  assign o_latch_data = r_latch_data;
  assign o_latch_clk  = r_latch_clk;
  assign o_layer_en   = r_layer_en;
  assign o_oe_n       = r_oe_n;
  assign o_layer_idx  = r_layer_idx;
  assign o_frame_done = r_frame_done;

endmodule
